// File: rtl/uart_tx_arbiter_if.sv
// Purpose: bundle of the request, packet-data and UART handshake signals around uart_tx_arbiter.
// Latency: none, wiring only.
// Backpressure: tx_busy from the UART is the only stall; requesters simply hold req high until served.
// Ports: req/len_a/len_b/data_a/data_b/tx_busy flow into the arbiter;
//        tx_start/tx_data/grant/byte_idx/done/busy flow out of it.
// master = arbiter side, slave = requesters plus UART side.
interface uart_tx_arbiter_if #(
    parameter int LEN_W = 11
);
    logic [1:0]       req;
    logic [LEN_W-1:0] len_a;
    logic [LEN_W-1:0] len_b;
    logic [7:0]       data_a;
    logic [7:0]       data_b;
    logic             tx_busy;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic [1:0]       grant;
    logic [LEN_W-1:0] byte_idx;
    logic [1:0]       done;
    logic             busy;

    modport master (
        input  req, len_a, len_b, data_a, data_b, tx_busy,
        output tx_start, tx_data, grant, byte_idx, done, busy
    );

    modport slave (
        output req, len_a, len_b, data_a, data_b, tx_busy,
        input  tx_start, tx_data, grant, byte_idx, done, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter that streams a whole packet from requester A or B into one UART.
// Latency: req sampled at edge k -> grant from k+1, tx_start seen high at edge k+2; one FETCH cycle per byte.
// Backpressure: each byte waits for tx_busy to rise and fall, then INTER_BYTE_DELAY idle cycles before the next.
// Ports: clk, reset (async, active-high), bus (uart_tx_arbiter_if.master, LEN_W must match the interface).
module uart_tx_arbiter #(
    parameter int INTER_BYTE_DELAY = 1000000,
    parameter int LEN_W            = 11
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_arbiter_if.master  bus
);

    // Counter only has to reach INTER_BYTE_DELAY-1.
    localparam int GAP_W = (INTER_BYTE_DELAY > 1) ? $clog2(INTER_BYTE_DELAY) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((INTER_BYTE_DELAY > 0) ? (INTER_BYTE_DELAY - 1) : 0);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        WAIT_HI,
        WAIT_LO,
        GAP,
        DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_b;       // 1 when B owned the most recent packet

    logic             tx_start_q;
    logic [7:0]       tx_data_q;
    logic [1:0]       grant_q;
    logic [LEN_W-1:0] byte_idx_q;
    logic [1:0]       done_q;
    logic             busy_q;

    logic             pick_b;
    logic [LEN_W-1:0] len_sel;

    // B wins when it asks alone, or when both ask and A had the last turn.
    always_comb begin
        pick_b  = bus.req[1] && (!bus.req[0] || !last_b);
        len_sel = pick_b ? bus.len_b : bus.len_a;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            gap_cnt    <= '0;
            last_b     <= 1'b1;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_q    <= 2'b00;
            byte_idx_q <= '0;
            done_q     <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 2'b00;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_q    <= pick_b ? 2'b10 : 2'b01;
                        byte_idx_q <= '0;
                        len_q      <= len_sel;
                        busy_q     <= 1'b1;
                        state      <= (len_sel == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    // byte_idx settled one cycle ago, so the read data is valid now.
                    tx_data_q  <= grant_q[1] ? bus.data_b : bus.data_a;
                    tx_start_q <= 1'b1;
                    state      <= START;
                end
                START: begin
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        if (byte_idx_q == len_q - LEN_W'(1)) begin
                            state <= DONE;
                        end else begin
                            byte_idx_q <= byte_idx_q + LEN_W'(1);
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end
                    end
                end
                GAP: begin
                    // A zero delay still spends this single cycle here.
                    if (gap_cnt >= GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= FETCH;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= grant_q;
                    last_b  <= grant_q[1];
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.grant    = grant_q;
    assign bus.byte_idx = byte_idx_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter INTER_BYTE_DELAY, default 1000000: idle clk cycles between tx_busy falling and the next tx_start within one packet.
REQ-002 Parameter LEN_W, default 11: width of the length and byte-index fields.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req  in  2  per-requester packet request, level; bit0 = A (scalar result), bit1 = B (vector read stream).
REQ-006 len_a, len_b  in  LEN_W  packet length in bytes, sampled at grant.
REQ-007 data_a, data_b  in  8  byte at byte_idx, valid one cycle after byte_idx changes (BRAM-style read latency).
REQ-008 tx_busy  in  1  UART transmitter busy.
REQ-009 tx_start  out  1  one-cycle start pulse to the UART.
REQ-010 tx_data  out  8  registered byte to transmit, stable from tx_start until tx_busy falls.
REQ-011 grant  out  2  one-hot owner of the UART; 00 when idle.
REQ-012 byte_idx  out  LEN_W  index of the byte being fetched for the granted requester.
REQ-013 done  out  2  one-cycle pulse on the bit of the requester whose packet completed.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 States: IDLE, FETCH, START, WAIT_HI, WAIT_LO, GAP, DONE.
REQ-016 IDLE: if req != 00 at an edge, set grant, clear byte_idx, latch the granted len, and go to FETCH.
- If the latched len is 0, go directly to DONE.
REQ-017 Arbitration is round-robin between A and B.
- If both requests are high, grant the requester not granted last.
- last_grant resets to B, so A wins the first contention.
REQ-018 A grant is locked for the whole packet.
- Deasserting req mid-packet does not abort the packet.
- A competing request waits until the packet finishes.
REQ-019 FETCH lasts exactly one cycle; on exit, register the granted data_x into tx_data and go to START.
REQ-020 START: assert tx_start for exactly one cycle, then go to WAIT_HI.
- Latency: req sampled at edge k gives grant valid from k+1 and tx_start high from k+2 to k+3.
REQ-021 WAIT_HI waits for tx_busy=1; WAIT_LO then waits for tx_busy=0.
- If tx_busy is already 1 on entry to WAIT_HI, advance on the next edge.
REQ-022 On leaving WAIT_LO:
- If byte_idx == latched len-1, go to DONE.
- Otherwise increment byte_idx and go to GAP.
REQ-023 GAP counts INTER_BYTE_DELAY cycles, then goes to FETCH.
- If INTER_BYTE_DELAY = 0, GAP lasts one cycle.
- The counter is wide enough for the parameter value and clears on each GAP entry.
REQ-024 DONE: pulse the matching done bit for one cycle, record last_grant, clear grant to 00, and return to IDLE.
- A new grant may occur on the next edge.
REQ-025 byte_idx never exceeds latched len-1 and does not wrap.
- len = 2^LEN_W-1 is legal.
REQ-026 len_x and data_x changes outside the defined sampling points have no effect.
REQ-027 tx_start is never asserted while grant == 00 or while tx_busy = 1.

Reset
REQ-028 Asserting reset forces all of the following immediately, including mid-packet, with no done pulse issued:
- state IDLE, tx_start 0, tx_data 00, grant 00, byte_idx 0, done 00, busy 0, GAP counter 0, last_grant B.
REQ-029 After reset deasserts, the first edge with req != 00 is treated as a fresh arbitration.

Verification (bench uses INTER_BYTE_DELAY=10; UART model raises tx_busy 1 cycle after tx_start and holds it for 20 cycles)
REQ-030 Scenario A-only:
- Stimulus: req=01, len_a=4, data_a=byte_idx+0x10.
- Response: tx_data sequence 10,11,12,13; 10 idle cycles between each busy fall and the next tx_start; done=01 once; grant returns to 00.
REQ-031 Scenario contention:
- Stimulus: req=11 from reset, len_a=2, len_b=3.
- Response: A served first (2 bytes), then B (3 bytes) with no intervening idle grant; done=01 then done=10.
REQ-032 Scenario round-robin:
- Stimulus: after a B packet completes, req=11.
- Response: A granted; after the A packet, B is granted.
REQ-033 Scenario zero length:
- Stimulus: req=10, len_b=0.
- Response: no tx_start; done=10 pulses 2 cycles after req is sampled.
REQ-034 Scenario reset mid-packet:
- Stimulus: assert reset during GAP of byte 1 of a 4-byte A packet.
- Response: outputs reach reset values without waiting for a clock edge, no done pulse; after release with req=01, transmission restarts at byte_idx 0.
REQ-035 Scenario request drop:
- Stimulus: deassert req bit A after the first tx_start of a 3-byte packet.
- Response: all 3 bytes are sent and done=01 pulses.
